// File: rtl/ldst_fsm_if.sv
// Handshake and bus-control bundle between the load/store sequencer and the datapath.
// master drives requests and memory ready; slave (the sequencer) drives the strobes.
interface ldst_fsm_if #(
  parameter int NUM_REGS = 5,
  parameter int SEL_W    = 6
);
  logic                fetch_done;
  logic                start;
  logic                is_store;
  logic [SEL_W-1:0]    src_sel;
  logic [SEL_W-1:0]    dst_sel;
  logic                mem_ready;
  logic [NUM_REGS-1:0] reg_out;
  logic [NUM_REGS-1:0] reg_in;
  logic                MARin;
  logic                MDR_tobusin;
  logic                MDR_frombusin;
  logic                MDROutEn;
  logic                EN;
  logic                RW;
  logic                busy;
  logic                done;
  logic                err;

  modport master (
    output fetch_done, start, is_store, src_sel, dst_sel, mem_ready,
    input  reg_out, reg_in, MARin, MDR_tobusin, MDR_frombusin, MDROutEn,
           EN, RW, busy, done, err
  );

  modport slave (
    input  fetch_done, start, is_store, src_sel, dst_sel, mem_ready,
    output reg_out, reg_in, MARin, MDR_tobusin, MDR_frombusin, MDROutEn,
           EN, RW, busy, done, err
  );
endinterface

// File: rtl/ldst_fsm.sv
// Single LOAD/STORE sequencer for the shared-bus datapath with variable-latency memory.
// Optional memory-wait timeout is enabled by defining LDST_TIMEOUT_EN.
module ldst_fsm #(
  parameter int NUM_REGS = 5,
  parameter int SEL_W    = 6,
  parameter int WAIT_W   = 4
) (
  input logic       clk,
  input logic       rst,
  ldst_fsm_if.slave bus
);

  // S_CAPT holds the freshly registered operands so the selector check runs off flops.
  typedef enum logic [2:0] {
    S_IDLE, S_CAPT, S_ADDR, S_MEM_RD, S_WB, S_DATA, S_MEM_WR, S_DONE
  } state_t;

  localparam logic [SEL_W:0] LP_NUM_REGS = (SEL_W+1)'(NUM_REGS);

  state_t              r_state;
  state_t              w_next;
  logic                r_isStore;
  logic [SEL_W-1:0]    r_src;
  logic [SEL_W-1:0]    r_dst;
  logic                r_err;
  logic                w_selBad;
  logic                w_inMem;
  logic                w_timeout;
  logic [NUM_REGS-1:0] w_srcHot;
  logic [NUM_REGS-1:0] w_dstHot;

  assign w_selBad = ({1'b0, r_src} >= LP_NUM_REGS) || ({1'b0, r_dst} >= LP_NUM_REGS);
  assign w_inMem  = (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
  assign w_srcHot = NUM_REGS'(1) << r_src;
  assign w_dstHot = NUM_REGS'(1) << r_dst;

`ifdef LDST_TIMEOUT_EN
  // Abort on the wait cycle that brings the counter to its all-ones limit.
  localparam logic [WAIT_W-1:0] LP_WAIT_LAST = {{(WAIT_W-1){1'b1}}, 1'b0};
  logic [WAIT_W-1:0] r_waitCnt;

  always_ff @(posedge clk) begin
    if (rst || !w_inMem) begin
      r_waitCnt <= '0;
    end else if (!bus.mem_ready) begin
      r_waitCnt <= r_waitCnt + 1'b1;
    end
  end

  assign w_timeout = w_inMem && !bus.mem_ready && (r_waitCnt == LP_WAIT_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_isStore <= 1'b0;
      r_src     <= '0;
      r_dst     <= '0;
    end else if (r_state == S_IDLE && bus.start && bus.fetch_done) begin
      r_isStore <= bus.is_store;
      r_src     <= bus.src_sel;
      r_dst     <= bus.dst_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (r_state == S_CAPT) begin
      r_err <= w_selBad;
    end else if (w_timeout) begin
      r_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (bus.start && bus.fetch_done) w_next = S_CAPT;
      S_CAPT:   w_next = w_selBad ? S_DONE : S_ADDR;
      S_ADDR:   w_next = r_isStore ? S_DATA : S_MEM_RD;
      S_MEM_RD: begin
        if (bus.mem_ready)  w_next = S_WB;
        else if (w_timeout) w_next = S_DONE;
      end
      S_WB:     w_next = S_DONE;
      S_DATA:   w_next = S_MEM_WR;
      S_MEM_WR: if (bus.mem_ready || w_timeout) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.reg_out       = '0;
    bus.reg_in        = '0;
    bus.MARin         = 1'b0;
    bus.MDR_tobusin   = 1'b0;
    bus.MDR_frombusin = 1'b0;
    bus.MDROutEn      = 1'b0;
    bus.EN            = 1'b0;
    bus.RW            = 1'b0;
    bus.done          = 1'b0;
    bus.err           = 1'b0;
    bus.busy          = (r_state != S_IDLE);
    case (r_state)
      S_ADDR: begin
        bus.reg_out = w_srcHot;
        bus.MARin   = 1'b1;
      end
      S_MEM_RD: begin
        bus.EN          = 1'b1;
        bus.RW          = 1'b1;
        bus.MDR_tobusin = bus.mem_ready;
      end
      S_WB: begin
        bus.MDROutEn = 1'b1;
        bus.reg_in   = w_dstHot;
      end
      S_DATA: begin
        bus.reg_out       = w_dstHot;
        bus.MDR_frombusin = 1'b1;
      end
      S_MEM_WR: bus.EN = 1'b1;
      S_DONE: begin
        bus.done = 1'b1;
        bus.err  = r_err;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/ldst_fsm.md
Name:
ldst_fsm

Overview:
- Parametrised successor to the single-register load sequencer in the microcontroller datapath.
- Runs one memory LOAD (mem[R_src] -> R_dst) or STORE (R_dst -> mem[R_src]) per start pulse. It drives the shared-bus register enables, the MAR/MDR strobes and the memory EN/RW lines.
- Adds the following over the previous generation:
  - register-file size set by parameter
  - store mode
  - variable-latency memory handshake
  - registered operand capture
  - error reporting for illegal selectors

Parameters:
- NUM_REGS, 5, number of bus registers; indices 0..NUM_REGS-2 are R0.., index NUM_REGS-1 is P0.
- SEL_W, 6, width of the src_sel/dst_sel operand fields.
- WAIT_W, 4, width of the memory-wait counter (timeout limit = 2^WAIT_W-1 cycles).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- fetch_done  in  1  instruction fetch complete; start is only accepted while high.
- start  in  1  request pulse; sampled in IDLE only.
- is_store  in  1  0=load, 1=store; captured with start.
- src_sel  in  SEL_W  address register index; captured with start.
- dst_sel  in  SEL_W  data register index; captured with start.
- mem_ready  in  1  memory access complete this cycle.
- reg_out  out  NUM_REGS  one-hot register-to-bus enable.
- reg_in  out  NUM_REGS  one-hot bus-to-register load.
- MARin  out  1  MAR loads from bus.
- MDR_tobusin  out  1  MDR loads from memory data.
- MDR_frombusin  out  1  MDR loads from bus.
- MDROutEn  out  1  MDR drives bus.
- EN  out  1  memory enable.
- RW  out  1  1=read, 0=write; valid only while EN=1.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  qualifies done; 1 = operation aborted.

Behaviour:
- On rst=1 at a clock edge:
  - state -> IDLE
  - captured operands and wait counter cleared
  - all outputs 0
- rst mid-operation aborts immediately: no done, no further strobes.
- All outputs are decoded from the registered state (Moore), except MDR_tobusin = (state==MEM_RD) & mem_ready.
- Capture: in IDLE, if start & fetch_done, register is_store, src_sel and dst_sel. Otherwise start is ignored.
- start while busy is ignored; there is no queueing.
- Selector check at capture: if src_sel>=NUM_REGS or dst_sel>=NUM_REGS, go to DONE with err=1. No reg_out, reg_in or EN is ever asserted on that path.
- States and transitions:
  - IDLE -> ADDR on valid capture.
  - ADDR: reg_out[src]=1, MARin=1; one cycle.
    - Load: ADDR -> MEM_RD.
    - Store: ADDR -> DATA.
  - MEM_RD: EN=1, RW=1. Stays until mem_ready=1, then -> WB.
  - WB: MDROutEn=1, reg_in[dst]=1; one cycle -> DONE.
  - DATA: reg_out[dst]=1, MDR_frombusin=1; one cycle -> MEM_WR.
  - MEM_WR: EN=1, RW=0. Stays until mem_ready=1, then -> DONE.
  - DONE: done=1, err as computed; one cycle -> IDLE.
- Latency with mem_ready=1 in the first memory cycle: start sampled at edge k, done high in the cycle after edge k+4 (load and store alike). Each extra wait cycle adds 1.
- mem_ready outside MEM_RD/MEM_WR is ignored.
- At most one bit of reg_out and of reg_in is high in any cycle. The two are never high together.
- src_sel==dst_sel is legal. A load then overwrites the address register in WB.
- fetch_done is only a start qualifier. Its fall mid-operation has no effect.

Optional Feature:
- Macro: LDST_TIMEOUT_EN.
- Defined:
  - The wait counter clears on entry to MEM_RD/MEM_WR and increments each cycle mem_ready=0.
  - When it reaches 2^WAIT_W-1 with mem_ready still 0, the next state is DONE with err=1. EN drops that edge.
  - A load that times out never asserts MDR_tobusin or reg_in.
- Undefined: the counter is absent; MEM_RD/MEM_WR wait indefinitely and err is only set by the selector check.

Test Plan:
- Reset: hold rst=1 for 2 cycles during MEM_RD -> next cycle all outputs 0, busy=0; no done ever follows.
- Load, no waits: fetch_done=1, start=1, is_store=0, src=1, dst=2, mem_ready=1 -> cycle sequence:
  - ADDR: reg_out=00010, MARin=1
  - MEM_RD: EN=1, RW=1, MDR_tobusin=1
  - WB: MDROutEn=1, reg_in=00100
  - DONE: done=1, err=0
- Store with 3 wait cycles: is_store=1, src=4 (P0), dst=0, mem_ready rises on the 4th MEM_WR cycle ->
  - reg_out=10000 with MARin
  - then reg_out=00001 with MDR_frombusin
  - EN=1, RW=0 for 4 cycles
  - done on edge k+7
- Illegal selector: src=5 with NUM_REGS=5 -> done=1, err=1 two cycles after start is sampled (DONE entered directly from capture); reg_out/reg_in/EN stay 0 throughout.
- Gating: start=1 with fetch_done=0 -> stays IDLE. A second start pulsed during MEM_RD -> ignored; exactly one done.
- Timeout (LDST_TIMEOUT_EN, WAIT_W=4): mem_ready held 0 -> done=1, err=1 after 15 wait cycles; reg_in never asserted.
